// File: rtl/dram_burst_model.sv
// dram_burst_model: single-clock word-addressed DRAM model with a fixed-latency
// read pipe, Ready/DataValid handshake, wrapping bursts and an error pulse.
//
// Ports:
//   Clk1       sole clock, all state changes on the rising edge
//   Reset      synchronous, active-high; flushes the read pipe, keeps Memory
//   RD / WR    request strobes, sampled only while Ready=1
//   Burst      with RD/WR: request is BURST_LEN beats wrapping in its aligned block
//   Addr       request (base) word address
//   DataIn     write data, one word per write beat
//   Ready      model accepts a new request this cycle
//   DataOut    read data, holds its last value while DataValid=0
//   DataValid  DataOut holds a read beat
//   Err        one-cycle error pulse (RD&WR conflict, out-of-range beat)
//
// Timing: a read beat sampled at edge E is registered onto DataOut/DataValid at
// edge E+READ_LAT-1, so a consumer samples it at edge E+READ_LAT. Write-beat and
// conflict errors appear right after the offending edge; a read-beat error is
// aligned with that beat's DataValid.
module dram_burst_model #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned DEPTH     = 65536,
    parameter int unsigned READ_LAT  = 2,
    parameter int unsigned BURST_LEN = 4
) (
    input  logic              Clk1,
    input  logic              Reset,
    input  logic              RD,
    input  logic              WR,
    input  logic              Burst,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] DataIn,
    output logic              Ready,
    output logic [DATA_W-1:0] DataOut,
    output logic              DataValid,
    output logic              Err
);

    localparam int unsigned OFF_W = $clog2(BURST_LEN);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned AW1   = ADDR_W + 1;
    localparam logic [ADDR_W:0] DEPTH_X = AW1'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BRD  = 2'd1,
        BWR  = 2'd2
    } state_t;

    // Word storage; left unreset so contents survive Reset and can be dumped.
    logic [DATA_W-1:0] Memory [DEPTH];

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] base, base_nxt;
    logic [OFF_W-1:0]  beat, beat_nxt;

    logic              rd_beat, wr_beat, conflict;
    logic [ADDR_W-1:0] beat_addr;
    logic              oor;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] rd_word;

    logic              src_v, src_e;
    logic [DATA_W-1:0] src_d;

    // State register
    always_ff @(posedge Clk1) begin
        if (Reset) begin
            state <= IDLE;
            base  <= '0;
            beat  <= '0;
        end else begin
            state <= state_nxt;
            base  <= base_nxt;
            beat  <= beat_nxt;
        end
    end

    // Next state, beat address and per-cycle access strobes
    always_comb begin
        state_nxt = state;
        base_nxt  = base;
        beat_nxt  = beat;
        rd_beat   = 1'b0;
        wr_beat   = 1'b0;
        conflict  = 1'b0;
        beat_addr = Addr;
        case (state)
            IDLE: begin
                if (RD && WR) begin
                    conflict = 1'b1;
                end else if (RD || WR) begin
                    rd_beat = RD;
                    wr_beat = WR;
                    if (Burst) begin
                        state_nxt = RD ? BRD : BWR;
                        base_nxt  = Addr;
                        beat_nxt  = OFF_W'(1);
                    end
                end
            end
            BRD, BWR: begin
                // Low bits add modulo BURST_LEN: wrap inside the aligned block.
                beat_addr = {base[ADDR_W-1:OFF_W], base[OFF_W-1:0] + beat};
                rd_beat   = (state == BRD);
                wr_beat   = (state == BWR);
                beat_nxt  = beat + OFF_W'(1);
                if (beat == OFF_W'(BURST_LEN - 1)) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign oor     = ({1'b0, beat_addr} >= DEPTH_X);
    assign idx     = IDX_W'(beat_addr);
    assign rd_word = oor ? '0 : Memory[idx];

    // Memory write port; out-of-range beats are dropped.
    always_ff @(posedge Clk1) begin
        if (!Reset && wr_beat && !oor) begin
            Memory[idx] <= DataIn;
        end
    end

    // Read pipe: READ_LAT-1 stages in front of the output register.
    generate
        if (READ_LAT <= 1) begin : g_lat1
            assign src_v = rd_beat;
            assign src_d = rd_word;
            assign src_e = rd_beat && oor;
        end else begin : g_pipe
            localparam int unsigned STG = READ_LAT - 1;
            logic [STG-1:0]    stg_v;
            logic [STG-1:0]    stg_e;
            logic [DATA_W-1:0] stg_d [STG];

            // Valid/error bits are flushed by Reset; data needs no reset.
            always_ff @(posedge Clk1) begin
                if (Reset) begin
                    stg_v <= '0;
                    stg_e <= '0;
                end else begin
                    stg_v[0] <= rd_beat;
                    stg_e[0] <= rd_beat && oor;
                    for (int i = 1; i < int'(STG); i++) begin
                        stg_v[i] <= stg_v[i-1];
                        stg_e[i] <= stg_e[i-1];
                    end
                end
            end

            always_ff @(posedge Clk1) begin
                stg_d[0] <= rd_word;
                for (int i = 1; i < int'(STG); i++) begin
                    stg_d[i] <= stg_d[i-1];
                end
            end

            assign src_v = stg_v[STG-1];
            assign src_d = stg_d[STG-1];
            assign src_e = stg_e[STG-1];
        end
    endgenerate

    // Registered outputs
    always_ff @(posedge Clk1) begin
        if (Reset) begin
            Ready     <= 1'b1;
            DataValid <= 1'b0;
            DataOut   <= '0;
            Err       <= 1'b0;
        end else begin
            Ready     <= (state_nxt == IDLE);
            DataValid <= src_v;
            if (src_v) begin
                DataOut <= src_d;
            end
            Err       <= (src_v && src_e) || conflict || (wr_beat && oor);
        end
    end

endmodule

// File: tb/tb_dram_burst_model.sv
// Directed bench for dram_burst_model: three instances share one stimulus
// stream -- u_a default parameters, u_b with DEPTH=1024 for range errors,
// u_c with DATA_W=32 and READ_LAT=1.
module tb_dram_burst_model;

    logic        clk = 1'b0;
    logic        rst, rd, wr, burst;
    logic [15:0] addr;
    logic [31:0] din;

    logic        a_ready, a_dv, a_err;
    logic [15:0] a_do;
    logic        b_ready, b_dv, b_err;
    logic [15:0] b_do;
    logic        c_ready, c_dv, c_err;
    logic [31:0] c_do;

    int n_assert = 0;
    int n_fail   = 0;

    logic [15:0] bexp [4];

    always #5 clk = ~clk;

    dram_burst_model u_a (
        .Clk1(clk), .Reset(rst), .RD(rd), .WR(wr), .Burst(burst), .Addr(addr),
        .DataIn(din[15:0]), .Ready(a_ready), .DataOut(a_do), .DataValid(a_dv), .Err(a_err)
    );

    dram_burst_model #(.DEPTH(1024)) u_b (
        .Clk1(clk), .Reset(rst), .RD(rd), .WR(wr), .Burst(burst), .Addr(addr),
        .DataIn(din[15:0]), .Ready(b_ready), .DataOut(b_do), .DataValid(b_dv), .Err(b_err)
    );

    dram_burst_model #(.DATA_W(32), .READ_LAT(1)) u_c (
        .Clk1(clk), .Reset(rst), .RD(rd), .WR(wr), .Burst(burst), .Addr(addr),
        .DataIn(din), .Ready(c_ready), .DataOut(c_do), .DataValid(c_dv), .Err(c_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        bexp[0] = 16'h1111; bexp[1] = 16'h2222; bexp[2] = 16'h3333; bexp[3] = 16'h4444;
        rst = 1'b1; rd = 1'b0; wr = 1'b0; burst = 1'b0; addr = '0; din = '0;
        repeat (2) cyc();

        // Reset state
        chk("rst_ready",  32'(a_ready), 32'd1);
        chk("rst_dv",     32'(a_dv),    32'd0);
        chk("rst_do",     32'(a_do),    32'd0);
        chk("rst_err",    32'(a_err),   32'd0);
        chk("rst_c_do",   c_do,         32'd0);
        chk("rst_c_rdy",  32'(c_ready), 32'd1);

        // Single write then single read of 0x0010
        rst = 1'b0; wr = 1'b1; addr = 16'h0010; din = 32'hDEADBEEF;
        cyc();
        chk("s1_ready_w", 32'(a_ready), 32'd1);
        wr = 1'b0; rd = 1'b1;
        cyc();
        chk("s1_c_dv",    32'(c_dv),    32'd1);
        chk("s1_c_do",    c_do,         32'hDEADBEEF);
        chk("s1_a_dv_early", 32'(a_dv), 32'd0);
        chk("s1_ready_r", 32'(a_ready), 32'd1);
        rd = 1'b0;
        cyc();
        chk("s1_a_dv",    32'(a_dv),    32'd1);
        chk("s1_a_do",    32'(a_do),    32'h0000BEEF);
        chk("s1_ready_d", 32'(a_ready), 32'd1);
        chk("s1_c_dv_off", 32'(c_dv),   32'd0);

        // Burst write, base 0x0006; Addr changes during beats must be ignored
        wr = 1'b1; burst = 1'b1; addr = 16'h0006; din = 32'h1111;
        cyc();
        chk("bw_ready0", 32'(a_ready), 32'd0);
        wr = 1'b0; burst = 1'b0; addr = 16'h0055; din = 32'h2222;
        cyc();
        chk("bw_ready1", 32'(a_ready), 32'd0);
        din = 32'h3333;
        cyc();
        chk("bw_ready2", 32'(a_ready), 32'd0);
        din = 32'h4444;
        cyc();
        chk("bw_ready3", 32'(a_ready), 32'd1);
        chk("bw_mem6", 32'(u_a.Memory[6]), 32'h1111);
        chk("bw_mem7", 32'(u_a.Memory[7]), 32'h2222);
        chk("bw_mem4", 32'(u_a.Memory[4]), 32'h3333);
        chk("bw_mem5", 32'(u_a.Memory[5]), 32'h4444);

        // Burst read, base 0x0006
        rd = 1'b1; burst = 1'b1; addr = 16'h0006;
        cyc();
        chk("br_ready0", 32'(a_ready), 32'd0);
        chk("br_dv0",    32'(a_dv),    32'd0);
        rd = 1'b0; burst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("br_dv",    32'(a_dv),    32'd1);
            chk("br_do",    32'(a_do),    32'(bexp[i]));
            chk("br_ready", 32'(a_ready), (i >= 2) ? 32'd1 : 32'd0);
        end
        cyc();
        chk("br_dv_end", 32'(a_dv), 32'd0);
        chk("br_hold",   32'(a_do), 32'h4444);

        // Back-to-back single reads of 1,2,3
        wr = 1'b1; addr = 16'h0001; din = 32'hA001;
        cyc();
        addr = 16'h0002; din = 32'hA002;
        cyc();
        addr = 16'h0003; din = 32'hA003;
        cyc();
        wr = 1'b0; rd = 1'b1; addr = 16'h0001;
        cyc();
        chk("b2b_dv_pre", 32'(a_dv), 32'd0);
        addr = 16'h0002;
        cyc();
        chk("b2b_dv1", 32'(a_dv), 32'd1);
        chk("b2b_do1", 32'(a_do), 32'hA001);
        addr = 16'h0003;
        cyc();
        chk("b2b_dv2", 32'(a_dv), 32'd1);
        chk("b2b_do2", 32'(a_do), 32'hA002);
        chk("b2b_ready", 32'(a_ready), 32'd1);
        rd = 1'b0;
        cyc();
        chk("b2b_dv3", 32'(a_dv), 32'd1);
        chk("b2b_do3", 32'(a_do), 32'hA003);
        cyc();
        chk("b2b_dv_end", 32'(a_dv), 32'd0);

        // RD=WR=1 conflict at 0x0020
        wr = 1'b1; addr = 16'h0020; din = 32'h5A5A;
        cyc();
        rd = 1'b1; din = 32'hFFFF;
        cyc();
        chk("cf_err",   32'(a_err),   32'd1);
        chk("cf_ready", 32'(a_ready), 32'd1);
        chk("cf_dv",    32'(a_dv),    32'd0);
        rd = 1'b0; wr = 1'b0;
        cyc();
        chk("cf_err_off", 32'(a_err), 32'd0);
        chk("cf_dv_late", 32'(a_dv),  32'd0);
        chk("cf_mem20",   32'(u_a.Memory[32]), 32'h5A5A);

        // Out-of-range read on the 1024-word instance
        rd = 1'b1; addr = 16'h0400;
        cyc();
        chk("oor_err_early", 32'(b_err), 32'd0);
        chk("oor_dv_early",  32'(b_dv),  32'd0);
        chk("oor_do_hold",   32'(b_do),  32'hA003);
        rd = 1'b0;
        cyc();
        chk("oor_dv",  32'(b_dv),  32'd1);
        chk("oor_do",  32'(b_do),  32'd0);
        chk("oor_err", 32'(b_err), 32'd1);
        chk("oor_a_err", 32'(a_err), 32'd0);
        cyc();
        chk("oor_err_off", 32'(b_err), 32'd0);
        chk("oor_dv_off",  32'(b_dv),  32'd0);

        // Out-of-range write on the 1024-word instance
        wr = 1'b1; addr = 16'h0401; din = 32'h1234;
        cyc();
        chk("oow_err",   32'(b_err), 32'd1);
        chk("oow_a_err", 32'(a_err), 32'd0);
        wr = 1'b0;
        cyc();
        chk("oow_err_off", 32'(b_err), 32'd0);

        // Burst read interrupted by Reset on beat 2
        rd = 1'b1; burst = 1'b1; addr = 16'h0006;
        cyc();
        chk("rb_ready0", 32'(a_ready), 32'd0);
        rd = 1'b0; burst = 1'b0;
        cyc();
        chk("rb_dv0", 32'(a_dv), 32'd1);
        chk("rb_do0", 32'(a_do), 32'h1111);
        rst = 1'b1;
        cyc();
        chk("rb_ready", 32'(a_ready), 32'd1);
        chk("rb_dv",    32'(a_dv),    32'd0);
        chk("rb_err",   32'(a_err),   32'd0);
        chk("rb_do",    32'(a_do),    32'd0);
        rst = 1'b0;
        cyc();
        chk("rb_dv_p1",    32'(a_dv),    32'd0);
        chk("rb_ready_p1", 32'(a_ready), 32'd1);
        cyc();
        chk("rb_dv_p2", 32'(a_dv), 32'd0);
        rd = 1'b1; addr = 16'h0010;
        cyc();
        chk("rs_dv_early", 32'(a_dv), 32'd0);
        chk("rs_c_dv",     32'(c_dv), 32'd1);
        chk("rs_c_do",     c_do,      32'hDEADBEEF);
        rd = 1'b0;
        cyc();
        chk("rs_dv",  32'(a_dv),  32'd1);
        chk("rs_do",  32'(a_do),  32'h0000BEEF);
        chk("rs_err", 32'(a_err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
